// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encoding and frame-length helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef logic [2:0] tx_state_t;

   localparam tx_state_t ST_IDLE   = 3'd0;
   localparam tx_state_t ST_START  = 3'd1;
   localparam tx_state_t ST_DATA   = 3'd2;
   localparam tx_state_t ST_PARITY = 3'd3;
   localparam tx_state_t ST_STOP   = 3'd4;

   // Clocks occupied by one complete frame, start bit through last stop bit.
   function automatic int frame_clks(input int cpb, input int db, input int par, input int sb);
      return cpb * (1 + db + ((par != PAR_NONE) ? 1 : 0) + sb);
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter, 0..CLKS_PER_BIT-1, held at zero while cleared.
// o_Bit_End marks the last clock of each bit period.
module uart_bit_timer (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_Clear,
   input  logic [15:0] i_Clks_Per_Bit,
   output logic        o_Bit_End
);

   logic [15:0] cnt;
   logic        at_end;

   assign at_end    = (cnt == i_Clks_Per_Bit - 16'd1);
   assign o_Bit_End = at_end && !i_Clear;

   always_ff @(posedge i_Clock) begin
      if (i_Reset || i_Clear)
         cnt <= '0;
      else if (at_end)
         cnt <= '0;
      else
         cnt <= cnt + 16'd1;
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-entry holding register so that
// consecutive frames leave the pin back-to-back without an idle gap.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter logic [15:0] CLKS_PER_BIT = 16'd50,
   parameter int          DATA_BITS    = 8,
   parameter int          PARITY       = 0,
   parameter int          STOP_BITS    = 1
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic                 i_Tx_DV,
   input  logic [DATA_BITS-1:0] i_Tx_Byte,
   output logic                 o_Tx_Ready,
   output logic                 o_Tx_Active,
   output logic                 o_Tx_Serial,
   output logic                 o_Tx_Done
);

   if (CLKS_PER_BIT < 16'd2) begin : g_bad_cpb
      $error("uart_tx_cfg: CLKS_PER_BIT must be 2..65535");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_sb
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
   end

   localparam int             BCW      = $clog2(DATA_BITS);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

   tx_state_t            state;
   logic [DATA_BITS-1:0] hold_data;
   logic [DATA_BITS-1:0] shreg;
   logic [BCW-1:0]       bit_cnt;
   logic                 hold_valid;
   logic                 par_bit;
   logic                 stop_cnt;
   logic                 bit_end;
   logic                 last_stop;
   logic                 load;

   uart_bit_timer u_timer (
      .i_Clock        (i_Clock),
      .i_Reset        (i_Reset),
      .i_Clear        (state == ST_IDLE),
      .i_Clks_Per_Bit (CLKS_PER_BIT),
      .o_Bit_End      (bit_end)
   );

   assign last_stop  = (STOP_BITS == 1) || stop_cnt;
   // The holding register is drained either from idle or at the very end of a frame.
   assign load       = hold_valid &&
                       ((state == ST_IDLE) || (state == ST_STOP && bit_end && last_stop));
   assign o_Tx_Ready = ~hold_valid;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (load) begin
         hold_valid <= 1'b0;
      end else if (i_Tx_DV && !hold_valid) begin
         hold_valid <= 1'b1;
         hold_data  <= i_Tx_Byte;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state       <= ST_IDLE;
         shreg       <= '0;
         par_bit     <= 1'b0;
         bit_cnt     <= '0;
         stop_cnt    <= 1'b0;
         o_Tx_Serial <= 1'b1;
         o_Tx_Active <= 1'b0;
         o_Tx_Done   <= 1'b0;
      end else begin
         o_Tx_Done <= 1'b0;
         // Parity is taken from the unshifted word at load time.
         if (load) begin
            shreg   <= hold_data;
            par_bit <= (PARITY == PAR_ODD) ? ~^hold_data : ^hold_data;
         end
         case (state)
            ST_IDLE: begin
               o_Tx_Serial <= 1'b1;
               if (load) begin
                  state       <= ST_START;
                  o_Tx_Serial <= 1'b0;
                  o_Tx_Active <= 1'b1;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  state       <= ST_DATA;
                  o_Tx_Serial <= shreg[0];
                  bit_cnt     <= '0;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  shreg <= shreg >> 1;
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt  <= '0;
                     stop_cnt <= 1'b0;
                     if (PARITY != PAR_NONE) begin
                        state       <= ST_PARITY;
                        o_Tx_Serial <= par_bit;
                     end else begin
                        state       <= ST_STOP;
                        o_Tx_Serial <= 1'b1;
                     end
                  end else begin
                     bit_cnt     <= bit_cnt + 1'b1;
                     o_Tx_Serial <= shreg[1];
                  end
               end
            end
            ST_PARITY: begin
               if (bit_end) begin
                  state       <= ST_STOP;
                  o_Tx_Serial <= 1'b1;
                  stop_cnt    <= 1'b0;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (last_stop) begin
                     o_Tx_Done <= 1'b1;
                     stop_cnt  <= 1'b0;
                     if (load) begin
                        state       <= ST_START;
                        o_Tx_Serial <= 1'b0;
                     end else begin
                        state       <= ST_IDLE;
                        o_Tx_Active <= 1'b0;
                        o_Tx_Serial <= 1'b1;
                     end
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end
            end
            default: begin
               state       <= ST_IDLE;
               o_Tx_Serial <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations side by side, a cycle-level frame model,
// directed literal checks and a randomized traffic phase.
module tb_uart_tx_cfg;

   localparam int N = 4;
   localparam int CPB_A [N] = '{4, 4, 4, 2};
   localparam int DB_A  [N] = '{8, 7, 7, 9};
   localparam int PAR_A [N] = '{0, 2, 1, 1};
   localparam int SB_A  [N] = '{1, 2, 2, 1};

   logic           i_Clock = 1'b0;
   logic           i_Reset;
   logic [N-1:0]   dv;
   logic [N-1:0]   ser;
   logic [N-1:0]   act;
   logic [N-1:0]   done;
   logic [N-1:0]   rdy;
   logic [8:0]     byte_r [N];

   int cyc         = 0;
   int vectors     = 0;
   int miscompares = 0;

   always #5 i_Clock = ~i_Clock;

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int DB = DB_A[g];
      uart_tx_cfg #(
         .CLKS_PER_BIT (16'(CPB_A[g])),
         .DATA_BITS    (DB),
         .PARITY       (PAR_A[g]),
         .STOP_BITS    (SB_A[g])
      ) u_dut (
         .i_Clock     (i_Clock),
         .i_Reset     (i_Reset),
         .i_Tx_DV     (dv[g]),
         .i_Tx_Byte   (byte_r[g][DB-1:0]),
         .o_Tx_Ready  (rdy[g]),
         .o_Tx_Active (act[g]),
         .o_Tx_Serial (ser[g]),
         .o_Tx_Done   (done[g])
      );
   end

   task automatic chk(input string name, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int flen(input int i);
      return CPB_A[i] * (1 + DB_A[i] + ((PAR_A[i] != 0) ? 1 : 0) + SB_A[i]);
   endfunction

   // Line value per bit slot, slot 0 first; unused upper slots read as idle (1).
   function automatic logic [15:0] frame_of(input int i, input logic [8:0] d);
      logic [15:0] f;
      int ones;
      int k;
      f    = '1;
      ones = 0;
      f[0] = 1'b0;
      for (int b = 0; b < DB_A[i]; b++) begin
         f[1+b] = d[b];
         ones  += int'(d[b]);
      end
      k = 1 + DB_A[i];
      if (PAR_A[i] == 1) f[k] = ((ones % 2) == 0);
      else if (PAR_A[i] == 2) f[k] = ((ones % 2) == 1);
      return f;
   endfunction

   logic        m_held  [N];
   logic        m_busy  [N];
   logic        m_done  [N];
   logic [8:0]  m_hb    [N];
   int          m_start [N];
   logic [15:0] m_frame [N];

   initial begin
      logic hp;
      for (int i = 0; i < N; i++) begin
         m_held[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_hb[i] = '0;
         m_start[i] = 0; m_frame[i] = '1;
      end
      forever begin
         @(posedge i_Clock);
         cyc = cyc + 1;
         for (int i = 0; i < N; i++) begin
            if (i_Reset) begin
               m_held[i] = 0; m_busy[i] = 0; m_done[i] = 0;
            end else begin
               hp        = m_held[i];
               m_done[i] = 0;
               if (m_busy[i] && cyc == m_start[i] + flen(i)) begin
                  m_done[i] = 1;
                  m_busy[i] = 0;
               end
               if (!m_busy[i] && hp) begin
                  m_busy[i]  = 1;
                  m_start[i] = cyc;
                  m_frame[i] = frame_of(i, m_hb[i]);
                  m_held[i]  = 0;
               end
               if (dv[i] && !hp) begin
                  m_held[i] = 1;
                  m_hb[i]   = byte_r[i];
               end
            end
         end
      end
   end

   // Every-cycle compare of all four outputs of every instance.
   initial begin
      int exp_ser;
      forever begin
         @(negedge i_Clock);
         if (cyc > 0) begin
            for (int i = 0; i < N; i++) begin
               exp_ser = 1;
               if (m_busy[i]) exp_ser = int'(m_frame[i][(cyc - m_start[i]) / CPB_A[i]]);
               chk($sformatf("serial[%0d]", i), int'(ser[i]),  exp_ser);
               chk($sformatf("active[%0d]", i), int'(act[i]),  int'(m_busy[i]));
               chk($sformatf("done[%0d]", i),   int'(done[i]), int'(m_done[i]));
               chk($sformatf("ready[%0d]", i),  int'(rdy[i]),  int'(!m_held[i]));
            end
         end
      end
   end

   // ---------------- directed sequences ----------------
   task automatic run_single(input int id, input logic [8:0] b, input int nbits,
                             input int cpb, input int exp_bits, input int exp_len);
      int dvc, st, rel, dpos, dcnt, t;
      logic [15:0] got;
      dv[id] = 1'b1; byte_r[id] = b; dvc = cyc;
      @(negedge i_Clock);
      dv[id] = 1'b0;
      t = 0;
      while (ser[id] !== 1'b0 && t < 10) begin
         @(negedge i_Clock);
         t++;
      end
      st = cyc;
      chk($sformatf("start_latency[%0d]", id), st - dvc, 2);
      got = '1; dpos = -1; dcnt = 0;
      for (int r = 0; r < exp_len + 4; r++) begin
         rel = cyc - st;
         if ((rel % cpb) == cpb / 2 && (rel / cpb) < nbits) got[rel / cpb] = ser[id];
         if (done[id]) begin
            dcnt++;
            dpos = rel;
         end
         @(negedge i_Clock);
      end
      chk($sformatf("frame_bits[%0d]", id), int'(got) & ((1 << nbits) - 1), exp_bits);
      chk($sformatf("done_pos[%0d]", id), dpos, exp_len);
      chk($sformatf("done_count[%0d]", id), dcnt, 1);
      chk($sformatf("idle_after[%0d]", id), int'(act[id]), 0);
   endtask

   task automatic back_to_back();
      int dvc, st, t, gap, rbad, nd, d1, d2;
      dv[0] = 1'b1; byte_r[0] = 9'h055; dvc = cyc;
      @(negedge i_Clock);
      dv[0] = 1'b0;
      st = dvc + 2;
      t  = 0;
      while (!rdy[0] && t < 20) begin
         @(negedge i_Clock);
         t++;
      end
      chk("b2b_ready_return", cyc - st, 0);
      dv[0] = 1'b1; byte_r[0] = 9'h00F;
      @(negedge i_Clock);
      dv[0] = 1'b0;
      gap = 0; rbad = 0; nd = 0; d1 = -1; d2 = -1;
      while (cyc < st + 90) begin
         if (cyc >= st && cyc < st + 80 && !act[0]) gap++;
         if (cyc < st + 40 && rdy[0]) rbad++;
         if (done[0]) begin
            nd++;
            if (d1 < 0) d1 = cyc; else d2 = cyc;
         end
         if (cyc == st + 80) chk("b2b_active_fall", int'(act[0]), 0);
         @(negedge i_Clock);
      end
      chk("b2b_active_gap", gap, 0);
      chk("b2b_ready_held", rbad, 0);
      chk("b2b_done_count", nd, 2);
      chk("b2b_done1_pos", d1 - st, 40);
      chk("b2b_done_spacing", d2 - d1, 40);
   endtask

   task automatic reset_mid_frame();
      int dvc, st, nd, low;
      dv[0] = 1'b1; byte_r[0] = 9'h0FF; dvc = cyc;
      @(negedge i_Clock);
      dv[0] = 1'b0;
      st = dvc + 2;
      @(negedge i_Clock);
      dv[0] = 1'b1; byte_r[0] = 9'h033;
      @(negedge i_Clock);
      dv[0] = 1'b0;
      chk("rst_held_ready", int'(rdy[0]), 0);
      while (cyc < st + 13) @(negedge i_Clock);
      chk("rst_pre_active", int'(act[0]), 1);
      i_Reset = 1'b1;
      @(negedge i_Clock);
      i_Reset = 1'b0;
      chk("rst_serial", int'(ser[0]), 1);
      chk("rst_active", int'(act[0]), 0);
      chk("rst_ready", int'(rdy[0]), 1);
      nd = 0; low = 0;
      repeat (80) begin
         @(negedge i_Clock);
         if (done[0]) nd++;
         if (!ser[0]) low++;
      end
      chk("rst_no_done", nd, 0);
      chk("rst_held_dropped", low, 0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int idle_bad;
      i_Reset = 1'b1;
      dv      = '0;
      for (int i = 0; i < N; i++) byte_r[i] = '0;
      repeat (3) @(negedge i_Clock);
      chk("reset_serial", int'(ser), 4'hF);
      chk("reset_ready",  int'(rdy), 4'hF);
      chk("reset_active", int'(act), 0);
      chk("reset_done",   int'(done), 0);
      i_Reset  = 1'b0;
      idle_bad = 0;
      repeat (50) begin
         @(negedge i_Clock);
         if (ser != 4'hF || act != 4'h0 || done != 4'h0) idle_bad++;
      end
      chk("idle_line", idle_bad, 0);

      run_single(0, 9'h0A5, 10, 4, 'h34A, 40);
      run_single(1, 9'h041, 11, 4, 'h682, 44);
      run_single(2, 9'h041, 11, 4, 'h782, 44);
      run_single(3, 9'h1FF, 12, 2, 'hBFE, 24);
      back_to_back();
      reset_mid_frame();

      repeat (4000) begin
         i_Reset = ($urandom_range(0, 1499) == 0);
         for (int i = 0; i < N; i++) begin
            dv[i]     = ($urandom_range(0, 3) == 0);
            byte_r[i] = 9'($urandom);
         end
         @(negedge i_Clock);
      end
      i_Reset = 1'b0;
      dv      = '0;
      repeat (100) @(negedge i_Clock);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
